// File: rtl/regset_arb_pkg.sv
// regset_arb_pkg: shared types for the regset arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester currently owns the regset
//   op_t    : operation latched at grant time (write flag, register select, data)
//   CNT_W   : width of the read-duration counter
package regset_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_A,
        OWN_B
    } owner_t;

    typedef struct packed {
        logic       wr;
        logic       sel;
        logic [7:0] d;
    } op_t;

    function automatic op_t make_op(input logic wr, input logic sel, input logic [7:0] d);
        op_t op;
        op.wr  = wr;
        op.sel = sel;
        op.d   = d;
        return op;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin winner select with its pointer register.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_req_a/i_req_b : pending requests
//   i_advance       : move the pointer away from i_last (end of a transaction)
//   i_last          : owner of the transaction that is finishing
//   o_winner        : combinational winner for the current requests
//   o_any           : at least one request is pending
// Parameter B_PRIO_INIT: pointer value after reset (0 = A favoured, 1 = B).
module rr_pick2
    import regset_arb_pkg::*;
#(
    parameter bit B_PRIO_INIT = 1'b0
) (
    input  logic   i_clk,
    input  logic   i_reset,
    input  logic   i_req_a,
    input  logic   i_req_b,
    input  logic   i_advance,
    input  owner_t i_last,
    output owner_t o_winner,
    output logic   o_any
);

    logic favour_b;

    always_comb begin
        o_any    = i_req_a | i_req_b;
        o_winner = OWN_A;
        if (i_req_a && i_req_b) begin
            o_winner = favour_b ? OWN_B : OWN_A;
        end else if (i_req_b) begin
            o_winner = OWN_B;
        end
    end

    // After a transaction the other requester is favoured next.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            favour_b <= B_PRIO_INIT;
        end else if (i_advance) begin
            favour_b <= (i_last == OWN_A);
        end
    end

endmodule

// File: rtl/regset_arbiter.sv
// regset_arbiter: shares the two-register regset (r_0/r_1) between requester A
// (CPU control sequencer) and requester B (debug/monitor port). One transaction
// at a time, round-robin between the requesters. A transaction is a single
// register write or a bus read held for READ_CYCLES cycles.
//
// Ports:
//   i_clk, i_reset               : clock, synchronous active-high reset
//   i_reqX                       : request, held until o_doneX
//   i_wrX, i_selX, i_dX          : op, register select and write data (sampled at grant)
//   o_gntX                       : requester X owns the regset (GRANT..DONE)
//   o_doneX                      : one-cycle pulse at end of X's transaction
//   o_d                          : write data to the regset
//   o_write0, o_write1           : write strobes for r_0 / r_1
//   o_busSel, o_busEn            : regset bus select and transmitter enable
//   o_busy                       : arbiter is not IDLE
//   i_lockA, i_lockB             : only with REGSET_ARB_LOCK_EN; holding lock (and
//                                  request) in DONE chains another transaction for
//                                  the same owner without releasing the regset.
//
// Parameters:
//   READ_CYCLES : cycles o_busEn is held for a read (1..15)
//   B_PRIO_INIT : initial round-robin pointer (0 = A first, 1 = B first)
//
// Optional feature macro: REGSET_ARB_LOCK_EN
module regset_arbiter
    import regset_arb_pkg::*;
#(
    parameter int unsigned READ_CYCLES = 2,
    parameter bit          B_PRIO_INIT = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_reqA,
    input  logic       i_wrA,
    input  logic       i_selA,
    input  logic [7:0] i_dA,
    output logic       o_gntA,
    output logic       o_doneA,
    input  logic       i_reqB,
    input  logic       i_wrB,
    input  logic       i_selB,
    input  logic [7:0] i_dB,
    output logic       o_gntB,
    output logic       o_doneB,
`ifdef REGSET_ARB_LOCK_EN
    input  logic       i_lockA,
    input  logic       i_lockB,
`endif
    output logic [7:0] o_d,
    output logic       o_write0,
    output logic       o_write1,
    output logic       o_busSel,
    output logic       o_busEn,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_CYCLES - 1);

    state_t           state;
    owner_t           owner;
    op_t              op;
    logic [CNT_W-1:0] cnt;

    owner_t pick_winner;
    logic   pick_any;
    logic   relock;
    logic   advance;
    op_t    op_a;
    op_t    op_b;
    op_t    winner_op;
    op_t    owner_op;

    always_comb begin
        op_a      = make_op(i_wrA, i_selA, i_dA);
        op_b      = make_op(i_wrB, i_selB, i_dB);
        winner_op = (pick_winner == OWN_A) ? op_a : op_b;
        owner_op  = (owner == OWN_A) ? op_a : op_b;
    end

`ifdef REGSET_ARB_LOCK_EN
    // A lock only counts while its owner still requests.
    assign relock = (owner == OWN_A) ? (i_lockA & i_reqA) : (i_lockB & i_reqB);
`else
    assign relock = 1'b0;
`endif

    // A chained (locked) transaction keeps the pointer where it is.
    assign advance = (state == DONE) && !relock;

    rr_pick2 #(
        .B_PRIO_INIT(B_PRIO_INIT)
    ) u_pick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_req_a  (i_reqA),
        .i_req_b  (i_reqB),
        .i_advance(advance),
        .i_last   (owner),
        .o_winner (pick_winner),
        .o_any    (pick_any)
    );

    assign o_busy = (state != IDLE);

    // Outputs are registered: each transition assigns the values the
    // destination state presents. Strobes, bus enable and done pulses default
    // to 0 every cycle so they can only last as long as a transition sets them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            owner    <= OWN_A;
            op       <= '0;
            cnt      <= '0;
            o_gntA   <= 1'b0;
            o_gntB   <= 1'b0;
            o_doneA  <= 1'b0;
            o_doneB  <= 1'b0;
            o_d      <= '0;
            o_write0 <= 1'b0;
            o_write1 <= 1'b0;
            o_busSel <= 1'b0;
            o_busEn  <= 1'b0;
        end else begin
            o_write0 <= 1'b0;
            o_write1 <= 1'b0;
            o_busEn  <= 1'b0;
            o_doneA  <= 1'b0;
            o_doneB  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        owner    <= pick_winner;
                        op       <= winner_op;
                        o_gntA   <= (pick_winner == OWN_A);
                        o_gntB   <= (pick_winner == OWN_B);
                        o_d      <= winner_op.d;
                        o_busSel <= winner_op.sel;
                    end
                end
                GRANT: begin
                    state <= ACCESS;
                    cnt   <= CNT_LOAD;
                    if (op.wr) begin
                        o_write0 <= !op.sel;
                        o_write1 <= op.sel;
                    end else begin
                        o_busEn <= 1'b1;
                    end
                end
                ACCESS: begin
                    // A write always takes one cycle; a read leaves once the
                    // counter loaded with READ_CYCLES-1 has run down to 0.
                    if (op.wr || cnt == '0) begin
                        state   <= DONE;
                        o_doneA <= (owner == OWN_A);
                        o_doneB <= (owner == OWN_B);
                    end else begin
                        cnt     <= cnt - 1'b1;
                        o_busEn <= 1'b1;
                    end
                end
                DONE: begin
                    if (relock) begin
                        state    <= GRANT;
                        op       <= owner_op;
                        o_d      <= owner_op.d;
                        o_busSel <= owner_op.sel;
                    end else begin
                        state    <= IDLE;
                        o_gntA   <= 1'b0;
                        o_gntB   <= 1'b0;
                        o_d      <= '0;
                        o_busSel <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regset_arbiter.sv
// tb_regset_arbiter: directed scenarios plus randomized traffic for
// regset_arbiter, checked every cycle against a transaction-level model that
// expands each granted request into its expected cycle-by-cycle output list.
// Build with +define+REGSET_ARB_LOCK_EN to also exercise the lock ports.
module tb_regset_arbiter;

    localparam int RC  = 2;
    localparam bit BPI = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       req[2];
    logic       wr[2];
    logic       sel[2];
    logic       lock[2];
    logic [7:0] d[2];

    logic       gntA, gntB, doneA, doneB;
    logic [7:0] dOut;
    logic       write0, write1, busSel, busEn, busy;

    int checkCount = 0;
    int passCount  = 0;
    bit modelValid = 1'b0;

    always #5 clk = ~clk;

    regset_arbiter #(
        .READ_CYCLES(RC),
        .B_PRIO_INIT(BPI)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_reqA  (req[0]),
        .i_wrA   (wr[0]),
        .i_selA  (sel[0]),
        .i_dA    (d[0]),
        .o_gntA  (gntA),
        .o_doneA (doneA),
        .i_reqB  (req[1]),
        .i_wrB   (wr[1]),
        .i_selB  (sel[1]),
        .i_dB    (d[1]),
        .o_gntB  (gntB),
        .o_doneB (doneB),
`ifdef REGSET_ARB_LOCK_EN
        .i_lockA (lock[0]),
        .i_lockB (lock[1]),
`endif
        .o_d     (dOut),
        .o_write0(write0),
        .o_write1(write1),
        .o_busSel(busSel),
        .o_busEn (busEn),
        .o_busy  (busy)
    );

    typedef struct packed {
        logic       gA;
        logic       gB;
        logic       dnA;
        logic       dnB;
        logic       w0;
        logic       w1;
        logic       sel;
        logic       en;
        logic       busy;
        logic [7:0] d;
    } exp_t;

    function automatic exp_t mk(input logic gA, input logic gB, input logic dnA,
                                input logic dnB, input logic w0, input logic w1,
                                input logic s, input logic en, input logic bz,
                                input logic [7:0] dd);
        exp_t e;
        e.gA = gA; e.gB = gB; e.dnA = dnA; e.dnB = dnB;
        e.w0 = w0; e.w1 = w1; e.sel = s; e.en = en; e.busy = bz; e.d = dd;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checkCount++;
        if (act !== expv) begin
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end else begin
            passCount++;
        end
    endtask

    // ---------------- reference model ----------------
    exp_t cur;
    exp_t q[$];
    bit   ptrB;
    bit   ownerB;

    // Expand one granted request into the outputs of every cycle it occupies.
    function automatic void buildTxn(input bit o);
        logic       w  = wr[o];
        logic       s  = sel[o];
        logic [7:0] dd = d[o];
        ownerB = o;
        q.push_back(mk(!o, o, 1'b0, 1'b0, 1'b0, 1'b0, s, 1'b0, 1'b1, dd));
        if (w) begin
            q.push_back(mk(!o, o, 1'b0, 1'b0, !s, s, s, 1'b0, 1'b1, dd));
        end else begin
            for (int i = 0; i < RC; i++)
                q.push_back(mk(!o, o, 1'b0, 1'b0, 1'b0, 1'b0, s, 1'b1, 1'b1, dd));
        end
        q.push_back(mk(!o, o, !o, o, 1'b0, 1'b0, s, 1'b0, 1'b1, dd));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            cur        = '0;
            ptrB       = BPI;
            modelValid = 1'b1;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.dnA || cur.dnB) begin
            if (lock[ownerB] && req[ownerB]) begin
                buildTxn(ownerB);
                cur = q.pop_front();
            end else begin
                ptrB = !ownerB;
                cur  = '0;
            end
        end else if (req[0] || req[1]) begin
            buildTxn(req[1] && (!req[0] || ptrB));
            cur = q.pop_front();
        end else begin
            cur = '0;
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("cycle", 32'(mk(gntA, gntB, doneA, doneB, write0, write1,
                                       busSel, busEn, busy, dOut)), 32'(cur));
            checkOutput("gnt_excl", 32'(gntA & gntB), 32'd0);
            checkOutput("wr_excl", 32'(write0 & write1), 32'd0);
            checkOutput("strobe_vs_en", 32'((write0 | write1) & busEn), 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic r, input logic w,
                                 input logic s, input logic [7:0] dd);
        req[idx] = r;
        wr[idx]  = w;
        sel[idx] = s;
        d[idx]   = dd;
    endtask

    task automatic doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(i, 1'b0, 1'b0, 1'b0, 8'h00);
            lock[i] = 1'b0;
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic randomStep(input int i);
        logic dn = (i == 0) ? doneA : doneB;
        logic gn = (i == 0) ? gntA : gntB;
        if (!req[i]) begin
            if ($urandom_range(2) == 0) req[i] = 1'b1;
        end else if (dn) begin
            if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (gn && $urandom_range(15) == 0) begin
            req[i] = 1'b0;
        end
        wr[i]  = 1'($urandom_range(1));
        sel[i] = 1'($urandom_range(1));
        d[i]   = 8'($urandom_range(255));
`ifdef REGSET_ARB_LOCK_EN
        lock[i] = ($urandom_range(3) == 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  ord[4];
        int  nOrd;
        bit  seen;
        bit  again;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(i, 1'b0, 1'b0, 1'b0, 8'h00);
            lock[i] = 1'b0;
        end
        repeat (3) tick();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_gnt", 32'({gntA, gntB}), 32'd0);
        reset = 1'b0;

        // A writes r_1 = 5A with B idle.
        doReset();
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'h5A);
        tick();
        checkOutput("t1_gntA", 32'(gntA), 32'd1);
        checkOutput("t1_setup_w1", 32'(write1), 32'd0);
        tick();
        checkOutput("t1_w1", 32'(write1), 32'd1);
        checkOutput("t1_d", 32'(dOut), 32'h5A);
        tick();
        checkOutput("t1_doneA", 32'(doneA), 32'd1);
        checkOutput("t1_w1_off", 32'(write1), 32'd0);
        req[0] = 1'b0;
        tick();
        checkOutput("t1_idle", 32'({gntA, busy}), 32'd0);

        // A reads r_0: bus enabled for exactly RC cycles.
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("t2_en1", 32'({busEn, busSel}), 32'b10);
        tick();
        checkOutput("t2_en2", 32'({busEn, busSel}), 32'b10);
        tick();
        checkOutput("t2_done", 32'({busEn, doneA}), 32'b01);
        req[0] = 1'b0;
        tick();

        // Both held from reset: strict alternation A, B, A, B.
        doReset();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h11);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 8'h22);
        nOrd = 0;
        for (int c = 0; c < 60 && nOrd < 4; c++) begin
            tick();
            if (doneA) begin ord[nOrd] = 0; nOrd++; end
            else if (doneB) begin ord[nOrd] = 1; nOrd++; end
        end
        checkOutput("t3_count", 32'(nOrd), 32'd4);
        for (int i = 0; i < nOrd; i++) checkOutput("t3_order", 32'(ord[i]), 32'(i % 2));

        // Reset during the second ACCESS cycle of a read.
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 8'h00);
        tick();
        tick();
        tick();
        checkOutput("t4_en_pre", 32'(busEn), 32'd1);
        reset  = 1'b1;
        req[0] = 1'b0;
        tick();
        checkOutput("t4_after", 32'({busEn, gntA, busy, doneA}), 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (4) begin
            tick();
            if (doneA) seen = 1'b1;
        end
        checkOutput("t4_no_done", 32'(seen), 32'd0);

        // A withdraws its request during GRANT.
        doReset();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h3C);
        tick();
        req[0] = 1'b0;
        seen   = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (doneA) seen = 1'b1;
        end
        checkOutput("t5_done", 32'(seen), 32'd1);
        again = 1'b0;
        repeat (6) begin
            tick();
            if (gntA) again = 1'b1;
        end
        checkOutput("t5_no_regrant", 32'(again), 32'd0);

`ifdef REGSET_ARB_LOCK_EN
        // Locked read r_0 then write r_0 = 01, B requesting throughout.
        begin
            int doneCnt = 0;
            int atB     = -1;
            bit wrote   = 1'b0;
            doReset();
            applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
            lock[0] = 1'b1;
            applyStimulus(1, 1'b1, 1'b1, 1'b1, 8'hB5);
            for (int c = 0; c < 60 && atB < 0; c++) begin
                tick();
                if (gntB && atB < 0) atB = doneCnt;
                if (write0 && dOut == 8'h01) wrote = 1'b1;
                if (doneA) begin
                    doneCnt++;
                    if (doneCnt == 1) applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h01);
                    else req[0] = 1'b0;
                end else if (doneCnt == 1 && gntA) begin
                    lock[0] = 1'b0;
                end
            end
            checkOutput("t6_lock_order", 32'(atB), 32'd2);
            checkOutput("t6_lock_write", 32'(wrote), 32'd1);
        end
`endif

        // Randomized traffic with occasional resets.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(199) == 0);
            randomStep(0);
            randomStep(1);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i]  = 1'b0;
            lock[i] = 1'b0;
        end
        repeat (30) tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
